// File: rtl/alarm_sched_pkg.sv
// Shared types, default timing constants and the round-robin search helper
// for the alarm buzzer scheduler.
package alarm_sched_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StOn      = 2'd1,
        StGap     = 2'd2,
        StRelease = 2'd3
    } state_e;

    localparam int unsigned DefNReq      = 3;
    localparam int unsigned DefOnCycles  = 50000000;
    localparam int unsigned DefGapCycles = 25000000;
    localparam int unsigned DefBeeps     = 3;
    localparam int unsigned DefCntW      = 27;
    localparam int unsigned MaxReq       = 8;

    // Returns {valid, idx}: first set bit of req searching last+1, last+2, ... mod n.
    function automatic logic [3:0] rr_pick(input logic [7:0] req, input logic [2:0] last,
                                           input int n);
        logic [3:0] res;
        int         c;
        res = '0;
        // Walk backwards so the nearest candidate is written last and wins.
        for (int k = n; k >= 1; k--) begin
            c = (int'(last) + k) % n;
            if (req[c[2:0]]) begin
                res = {1'b1, c[2:0]};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/alarm_rr_pick.sv
// Combinational round-robin picker: next requester after last that is asserting req.
module alarm_rr_pick
    import alarm_sched_pkg::*;
#(
    parameter int unsigned N_REQ = DefNReq,
    localparam int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic             valid,
    output logic [IDX_W-1:0] idx,
    output logic [N_REQ-1:0] onehot
);

    logic [3:0]       pick;
    logic [2:0]       pick_idx;
    logic [N_REQ-1:0] one;

    assign pick     = rr_pick(8'(req), 3'(last), int'(N_REQ));
    assign valid    = pick[3];
    assign pick_idx = pick[2:0];
    assign idx      = IDX_W'(pick_idx);
    assign one      = {{(N_REQ-1){1'b0}}, 1'b1};
    assign onehot   = valid ? (one << idx) : '0;

endmodule

// File: rtl/alarm_buzzer_scheduler.sv
// Round-robin owner of one shared buzzer; each grant plays BEEPS on/gap pulses.
// Optional urgent preemption by requester 0 is enabled with ALARM_PREEMPT_EN.
module alarm_buzzer_scheduler
    import alarm_sched_pkg::*;
#(
    parameter int unsigned N_REQ      = DefNReq,
    parameter int unsigned ON_CYCLES  = DefOnCycles,
    parameter int unsigned GAP_CYCLES = DefGapCycles,
    parameter int unsigned BEEPS      = DefBeeps,
    parameter int unsigned CNT_W      = DefCntW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic             buzz,
    output logic [N_REQ-1:0] sel,
    output logic             busy,
    output logic             done
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned BC_W  = $clog2(BEEPS + 1);
    localparam longint unsigned MaxCnt =
        64'((ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES) - 64'd1;

    if (N_REQ < 2 || N_REQ > MaxReq) begin : gen_n_req_err
        $error("N_REQ must be in 2..8");
    end
    if (ON_CYCLES < 1 || GAP_CYCLES < 1 || BEEPS < 1) begin : gen_timing_err
        $error("ON_CYCLES, GAP_CYCLES and BEEPS must be >= 1");
    end
    if (CNT_W < 64 && MaxCnt >= (64'd1 << CNT_W)) begin : gen_cnt_w_err
        $error("CNT_W too small for max(ON_CYCLES, GAP_CYCLES)-1");
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [BC_W-1:0]  beep_q, beep_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic             buzz_q, buzz_d;
    logic [N_REQ-1:0] sel_q, sel_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic [N_REQ-1:0] pick_onehot;

    alarm_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req    (req),
        .last   (last_q),
        .valid  (pick_valid),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        beep_d  = beep_q;
        grant_d = grant_q;
        owner_d = owner_q;
        last_d  = last_q;
        buzz_d  = buzz_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                grant_d = '0;
                buzz_d  = 1'b0;
                if (pick_valid) begin
                    state_d = StOn;
                    grant_d = pick_onehot;
                    owner_d = pick_idx;
                    buzz_d  = 1'b1;
                    timer_d = '0;
                    beep_d  = '0;
                end
            end
            StOn: begin
                buzz_d = 1'b1;
                if (timer_q == CNT_W'(ON_CYCLES - 1)) begin
                    timer_d = '0;
                    beep_d  = beep_q + BC_W'(1);
                    buzz_d  = 1'b0;
                    if (beep_q + BC_W'(1) == BC_W'(BEEPS)) begin
                        state_d = StRelease;
                        grant_d = '0;
                        done_d  = 1'b1;
                        last_d  = owner_q;
                    end else begin
                        state_d = StGap;
                    end
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            StGap: begin
                buzz_d = 1'b0;
                if (timer_q == CNT_W'(GAP_CYCLES - 1)) begin
                    timer_d = '0;
                    state_d = StOn;
                    buzz_d  = 1'b1;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            StRelease: begin
                state_d = StIdle;
                grant_d = '0;
                buzz_d  = 1'b0;
            end
            default: state_d = StIdle;
        endcase

`ifdef ALARM_PREEMPT_EN
        // Urgent requester 0 restarts the pattern; last is untouched so the
        // preempted owner keeps its round-robin slot.
        if ((state_q == StOn || state_q == StGap) && req[0] && !grant_q[0]) begin
            state_d = StOn;
            grant_d = {{(N_REQ-1){1'b0}}, 1'b1};
            owner_d = '0;
            buzz_d  = 1'b1;
            timer_d = '0;
            beep_d  = '0;
            done_d  = 1'b0;
            last_d  = last_q;
        end
`endif

        busy_d = (state_d != StIdle);
        sel_d  = grant_d & {N_REQ{buzz_d}};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            timer_q <= '0;
            beep_q  <= '0;
            grant_q <= '0;
            owner_q <= '0;
            last_q  <= IDX_W'(N_REQ - 1);
            buzz_q  <= 1'b0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (ena) begin
            state_q <= state_d;
            timer_q <= timer_d;
            beep_q  <= beep_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            buzz_q  <= buzz_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign grant = grant_q;
    assign buzz  = buzz_q;
    assign sel   = sel_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_alarm_buzzer_scheduler.sv
// Scoreboard bench: a grant-level timeline model predicts each completed grant,
// a monitor rebuilds grants from the DUT outputs and compares on every done pulse.
module tb_alarm_buzzer_scheduler;

    localparam int N     = 3;
    localparam int ON    = 4;
    localparam int GAP   = 2;
    localparam int BEEPS = 2;
    localparam int LEN   = BEEPS * ON + (BEEPS - 1) * GAP;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ena;
    logic [N-1:0] req;
    logic [N-1:0] grant;
    logic         buzz;
    logic [N-1:0] sel;
    logic         busy;
    logic         done;

    alarm_buzzer_scheduler #(
        .N_REQ      (N),
        .ON_CYCLES  (ON),
        .GAP_CYCLES (GAP),
        .BEEPS      (BEEPS),
        .CNT_W      (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .req   (req),
        .grant (grant),
        .buzz  (buzz),
        .sel   (sel),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int start;
        int len;
        int hi;
        int beeps;
    } txn_t;

    txn_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_done = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: time is counted in clock edges that actually update state.
    int m_ec = 0, m_last = N - 1, m_free = 0, m_cur = 0, m_start = 0, m_off = 0;
    bit m_active = 1'b0;

    always @(posedge clk) begin
        if (!rst_n || ena) m_ec++;
        if (!rst_n) begin
            m_active = 1'b0;
            m_last   = N - 1;
            m_free   = 0;
        end else if (ena) begin
            if (m_active) begin
                m_off++;
                if (m_off == LEN) begin
                    txn_t t;
                    m_active = 1'b0;
                    m_last   = m_cur;
                    m_free   = m_ec + 2;
                    t.idx = m_cur; t.start = m_start; t.len = LEN;
                    t.hi = BEEPS * ON; t.beeps = BEEPS;
                    sb_q.push_back(t);
                end
            end else if (m_ec >= m_free && req != '0) begin
                for (int k = N; k >= 1; k--) begin
                    if (req[(m_last + k) % N]) m_cur = (m_last + k) % N;
                end
                m_active = 1'b1;
                m_off    = 0;
                m_start  = m_ec;
            end
        end
    end

    // Monitor
    logic e_rst = 1'b0, e_en = 1'b0, started = 1'b0;
    int   mon_ec = 0;
    always @(posedge clk) begin
        e_rst   <= !rst_n;
        e_en    <= ena;
        started <= 1'b1;
        if (!rst_n || ena) mon_ec <= mon_ec + 1;
    end

    bit           trk = 1'b0;
    int           trk_idx, trk_start, trk_len, trk_hi, trk_beeps;
    logic [N-1:0] trk_grant;
    logic [8:0]   prev_vec;
    logic         prev_buzz = 1'b0;

    always @(negedge clk) begin
        logic [8:0] vec;
        vec = {grant, buzz, sel, busy, done};
        if (started) begin
            if (e_rst) begin
                chk("reset_outputs", int'(vec), 0);
                trk = 1'b0;
            end else if (!e_en) begin
                chk("hold_when_disabled", int'(vec), int'(prev_vec));
            end else begin
                chk("sel_eq_grant_and_buzz", int'(sel), int'(grant & {N{buzz}}));
                chk("grant_onehot0", int'($onehot0(grant)), 1);
                chk("busy", int'(busy), int'((grant != '0) || done));
                if (grant != '0) begin
                    if (!trk) begin
                        trk = 1'b1; trk_grant = grant; trk_start = mon_ec;
                        trk_len = 0; trk_hi = 0; trk_beeps = 0;
                        for (int i = 0; i < N; i++) if (grant[i]) trk_idx = i;
                    end else begin
                        chk("grant_stable", int'(grant), int'(trk_grant));
                    end
                    trk_len++;
                    if (buzz) trk_hi++;
                    if (buzz && !prev_buzz) trk_beeps++;
                end
                if (done) begin
                    n_done++;
                    chk("done_expected", int'(sb_q.size() != 0 && trk), 1);
                    if (sb_q.size() != 0) begin
                        txn_t t;
                        t = sb_q.pop_front();
                        chk("grant_idx", trk_idx, t.idx);
                        chk("grant_start", trk_start, t.start);
                        chk("grant_len", trk_len, t.len);
                        chk("buzz_high_cycles", trk_hi, t.hi);
                        chk("beep_count", trk_beeps, t.beeps);
                    end
                    trk = 1'b0;
                end
            end
        end
        prev_vec  = vec;
        prev_buzz = buzz;
    end

    task automatic step(input logic [N-1:0] r, input logic e, input logic rs, input int n);
        for (int i = 0; i < n; i++) begin
            req = r; ena = e; rst_n = rs;
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        req = '0; ena = 1'b1; rst_n = 1'b0;
        step(3'b000, 1'b1, 1'b0, 3);
        // Single held request, then release and idle.
        step(3'b010, 1'b1, 1'b1, 30);
        step(3'b000, 1'b1, 1'b1, 15);
        // All three requesting: round-robin rotation.
        step(3'b111, 1'b1, 1'b1, 50);
        step(3'b000, 1'b1, 1'b1, 15);
        // One-cycle pulse still gets the full pattern.
        step(3'b100, 1'b1, 1'b1, 1);
        step(3'b000, 1'b1, 1'b1, 20);
        // Reset inside the gap aborts without done.
        step(3'b100, 1'b1, 1'b1, 6);
        step(3'b100, 1'b1, 1'b0, 1);
        step(3'b100, 1'b1, 1'b1, 20);
        step(3'b000, 1'b1, 1'b1, 15);
        // Enable dropped during an ON phase.
        step(3'b010, 1'b1, 1'b1, 2);
        step(3'b000, 1'b0, 1'b1, 5);
        step(3'b000, 1'b1, 1'b1, 20);
        // Randomised traffic with occasional freezes and resets.
        for (int i = 0; i < 800; i++) begin
            logic [N-1:0] r;
            r = req;
            if ($urandom_range(0, 7) == 0) r = N'($urandom_range(0, 7));
            step(r, 1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 249) != 0), 1);
        end
        step(3'b000, 1'b1, 1'b1, 30);
        chk("scoreboard_drained", sb_q.size(), 0);
        chk("enough_grants", int'(n_done >= 10), 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
